// File: rtl/line_bus_pkg.sv
// Shared definitions for the line bus capture block: width limits, filter counter
// sizing and the snapshot record seen by the synchroniser controller.
package line_bus_pkg;

    localparam int LB_MAX_WIDTH = 64;
    localparam int LB_MAX_SYNC  = 4;

    // Snapshot as presented to the controller register file.
    typedef struct packed {
        logic                    valid;
        logic [LB_MAX_WIDTH-1:0] data;
    } lb_snapshot_t;

    // Counter must hold 0..filt_len without wrapping.
    function automatic int lb_cnt_width(input int filt_len);
        return $clog2(filt_len + 1);
    endfunction

endpackage

// File: rtl/line_bus_filter.sv
// One status line: SYNC_STAGES-deep synchroniser followed by the output flop, with
// an optional FILT_LEN-cycle stability filter when LINE_BUS_CAPTURE_FILTER_EN is defined.
module line_bus_filter
    import line_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    input  logic en,
    output logic out_q_o,
    output logic out_d_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_s;
    logic                   out_q;
    logic                   out_d;

    // Synchroniser shift chain, free-running regardless of en.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], line_i};
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef LINE_BUS_CAPTURE_FILTER_EN
    localparam int CW = lb_cnt_width(FILT_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Output follows s only after FILT_LEN consecutive enabled cycles of disagreement.
    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (!en) begin
            cnt_d = {CW{1'b0}};
        end else if (sync_s == out_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            out_d = sync_s;
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1'b1);
        end
    end

    // Filter counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [7:0] unused_filt_len_s;
    assign unused_filt_len_s = 8'(FILT_LEN);

    // Unfiltered build: output takes the synchronised value whenever enabled.
    always_comb begin
        out_d = out_q;
        if (en) begin
            out_d = sync_s;
        end else begin
            out_d = out_q;
        end
    end
`endif

    // Synchroniser and output state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            out_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            out_q  <= out_d;
        end
    end

    assign out_q_o = out_q;
    assign out_d_o = out_d;

endmodule

// File: rtl/line_bus_capture.sv
// Captures WIDTH asynchronous status lines, produces rise/fall pulses and a one-entry
// change snapshot with valid/ready and sticky overflow. Filter: LINE_BUS_CAPTURE_FILTER_EN.
module line_bus_capture
    import line_bus_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] lines,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             chg_valid,
    input  logic             chg_ready,
    output logic [WIDTH-1:0] chg_data,
    output logic             ovf,
    input  logic             ovf_clr
);

    logic [WIDTH-1:0] out_q_s;
    logic [WIDTH-1:0] out_d_s;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic             chg_valid_q;
    logic             chg_valid_d;
    logic [WIDTH-1:0] chg_data_q;
    logic [WIDTH-1:0] chg_data_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             chg_event_s;
    logic             ovf_set_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_line
        line_bus_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN)
        ) u_filt (
            .clk     (clk),
            .rst_n   (rst_n),
            .line_i  (lines[i]),
            .en      (en),
            .out_q_o (out_q_s[i]),
            .out_d_o (out_d_s[i])
        );
    end

    // Edge pulses are registered alongside the out update they describe.
    always_comb begin
        rise_d = out_d_s & ~out_q_s;
        fall_d = ~out_d_s & out_q_s;
    end

    assign chg_event_s = en & (|(rise_q | fall_q));

    // Snapshot register and sticky overflow; a new overflow beats a clear.
    always_comb begin
        chg_valid_d = chg_valid_q;
        chg_data_d  = chg_data_q;
        ovf_set_s   = 1'b0;
        if (chg_event_s) begin
            chg_valid_d = 1'b1;
            chg_data_d  = out_q_s;
            ovf_set_s   = chg_valid_q & ~chg_ready;
        end else if (chg_valid_q && chg_ready) begin
            chg_valid_d = 1'b0;
        end else begin
            chg_valid_d = chg_valid_q;
        end

        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Pulse, snapshot and overflow state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q      <= {WIDTH{1'b0}};
            fall_q      <= {WIDTH{1'b0}};
            chg_valid_q <= 1'b0;
            chg_data_q  <= {WIDTH{1'b0}};
            ovf_q       <= 1'b0;
        end else begin
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            chg_valid_q <= chg_valid_d;
            chg_data_q  <= chg_data_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out       = out_q_s;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign chg_valid = chg_valid_q;
    assign chg_data  = chg_data_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_line_bus_capture.sv
// Self-checking bench for line_bus_capture: per-cycle reference model, a vector table
// and hand-written timing sequences. Works with or without LINE_BUS_CAPTURE_FILTER_EN.
module tb_line_bus_capture;

    localparam int W  = 16;
    localparam int S  = 2;
    localparam int FL = 4;
`ifdef LINE_BUS_CAPTURE_FILTER_EN
    localparam int L  = FL;
`else
    localparam int L  = 1;
`endif
    localparam int SET = S + L + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  lines;
    logic          en;
    logic          chg_ready;
    logic          ovf_clr;
    logic [W-1:0]  out;
    logic [W-1:0]  rise;
    logic [W-1:0]  fall;
    logic          chg_valid;
    logic [W-1:0]  chg_data;
    logic          ovf;

    always #5 clk = ~clk;

    line_bus_capture #(
        .WIDTH       (W),
        .SYNC_STAGES (S),
        .FILT_LEN    (FL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lines     (lines),
        .en        (en),
        .out       (out),
        .rise      (rise),
        .fall      (fall),
        .chg_valid (chg_valid),
        .chg_ready (chg_ready),
        .chg_data  (chg_data),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: s is lines delayed S edges; a bit of out flips once the last
    // L enabled samples of s all disagree with it.
    typedef struct {
        logic         en;
        logic [W-1:0] s;
    } hist_t;

    logic [W-1:0] m_sync[$];
    hist_t        m_hist[$];
    logic [W-1:0] m_out, m_rise, m_fall, m_data;
    logic         m_valid, m_ovf;
    logic [W-1:0] seen_rise, seen_fall;

    task automatic model_reset();
        m_sync.delete();
        for (int i = 0; i < S; i++) m_sync.push_back({W{1'b0}});
        m_hist.delete();
        m_out   = {W{1'b0}};
        m_rise  = {W{1'b0}};
        m_fall  = {W{1'b0}};
        m_data  = {W{1'b0}};
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge();
        logic [W-1:0] s_pre;
        logic [W-1:0] nxt;
        logic         ev;
        logic         set_ovf;
        hist_t        h;
        s_pre = m_sync.pop_front();
        m_sync.push_back(lines);
        h.en = en;
        h.s  = s_pre;
        m_hist.push_back(h);
        if (m_hist.size() > L) void'(m_hist.pop_front());
        nxt = m_out;
        if (en && m_hist.size() == L) begin
            for (int b = 0; b < W; b++) begin
                logic all_diff;
                all_diff = 1'b1;
                foreach (m_hist[k])
                    if (!m_hist[k].en || m_hist[k].s[b] == m_out[b]) all_diff = 1'b0;
                if (all_diff) nxt[b] = ~m_out[b];
            end
        end
        ev      = en && ((m_rise | m_fall) != {W{1'b0}});
        set_ovf = 1'b0;
        if (ev) begin
            set_ovf = m_valid && !chg_ready;
            m_data  = m_out;
            m_valid = 1'b1;
        end else if (m_valid && chg_ready) begin
            m_valid = 1'b0;
        end
        if (set_ovf) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        m_rise = nxt & ~m_out;
        m_fall = ~nxt & m_out;
        m_out  = nxt;
    endtask

    task automatic check_all(input string name);
        checks++;
        if ({out, rise, fall, chg_data, chg_valid, ovf} !==
            {m_out, m_rise, m_fall, m_data, m_valid, m_ovf}) begin
            failures++;
            $display("FAIL %s t=%0t: got out=%h rise=%h fall=%h data=%h valid=%b ovf=%b, want out=%h rise=%h fall=%h data=%h valid=%b ovf=%b",
                     name, $time, out, rise, fall, chg_data, chg_valid, ovf,
                     m_out, m_rise, m_fall, m_data, m_valid, m_ovf);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input string name);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(name);
        seen_rise = seen_rise | rise;
        seen_fall = seen_fall | fall;
    endtask

    task automatic run(input int n, input string name);
        for (int i = 0; i < n; i++) step(name);
    endtask

    // Reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic apply_reset(input string name);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(name);
        check_val({name, "_out"}, 64'(out), 64'd0);
        check_val({name, "_valid"}, 64'(chg_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [W-1:0] lines;
        logic         en, rdy, clr;
        int           cyc;
        logic [W-1:0] exp_out;
        logic         exp_valid;
        logic [W-1:0] exp_data;
        logic         exp_ovf;
    } vec_t;

    vec_t tbl[15];

    initial begin
        rst_n     = 1'b0;
        lines     = 16'hFFFF;
        en        = 1'b1;
        chg_ready = 1'b0;
        ovf_clr   = 1'b0;
        seen_rise = {W{1'b0}};
        seen_fall = {W{1'b0}};
        model_reset();

        //                lines     en    rdy   clr   cyc        out       vld   data      ovf
        tbl[0]  = '{16'h0001, 1'b1, 1'b0, 1'b0, SET,       16'h0001, 1'b1, 16'h0001, 1'b0};
        tbl[1]  = '{16'h0003, 1'b1, 1'b0, 1'b0, SET,       16'h0003, 1'b1, 16'h0003, 1'b1};
        tbl[2]  = '{16'h0003, 1'b1, 1'b0, 1'b1, 1,         16'h0003, 1'b1, 16'h0003, 1'b0};
        tbl[3]  = '{16'h0007, 1'b1, 1'b0, 1'b0, S + L,     16'h0007, 1'b1, 16'h0003, 1'b0};
        tbl[4]  = '{16'h0007, 1'b1, 1'b1, 1'b0, 1,         16'h0007, 1'b1, 16'h0007, 1'b0};
        tbl[5]  = '{16'h0007, 1'b1, 1'b1, 1'b0, 1,         16'h0007, 1'b0, 16'h0007, 1'b0};
        tbl[6]  = '{16'h0027, 1'b0, 1'b0, 1'b0, 20,        16'h0007, 1'b0, 16'h0007, 1'b0};
        tbl[7]  = '{16'h0027, 1'b1, 1'b0, 1'b0, L - 1,     16'h0007, 1'b0, 16'h0007, 1'b0};
        tbl[8]  = '{16'h0027, 1'b1, 1'b0, 1'b0, 1,         16'h0027, 1'b0, 16'h0007, 1'b0};
        tbl[9]  = '{16'h0027, 1'b1, 1'b0, 1'b0, 2,         16'h0027, 1'b1, 16'h0027, 1'b0};
        tbl[10] = '{16'h0000, 1'b1, 1'b1, 1'b0, SET,       16'h0000, 1'b0, 16'h0000, 1'b0};
        tbl[11] = '{16'h0100, 1'b1, 1'b0, 1'b0, SET,       16'h0100, 1'b1, 16'h0100, 1'b0};
        tbl[12] = '{16'h0300, 1'b1, 1'b0, 1'b1, S + L + 1, 16'h0300, 1'b1, 16'h0300, 1'b1};
        tbl[13] = '{16'h0300, 1'b1, 1'b0, 1'b1, 1,         16'h0300, 1'b1, 16'h0300, 1'b0};
        tbl[14] = '{16'h0300, 1'b1, 1'b1, 1'b0, 1,         16'h0300, 1'b0, 16'h0300, 1'b0};

        // All lines high through reset: one rise of FFFF once filtered through.
        apply_reset("reset_state");
        for (int k = 1; k <= S + L + 1; k++) begin
            step("ffff_model");
            if (k == S + L - 1) check_val("ffff_out_before", 64'(out), 64'd0);
            if (k == S + L) begin
                check_val("ffff_out", 64'(out), 64'hFFFF);
                check_val("ffff_rise", 64'(rise), 64'hFFFF);
                check_val("ffff_valid_early", 64'(chg_valid), 64'd0);
            end
            if (k == S + L + 1) begin
                check_val("ffff_rise_done", 64'(rise), 64'd0);
                check_val("ffff_valid", 64'(chg_valid), 64'd1);
                check_val("ffff_data", 64'(chg_data), 64'hFFFF);
            end
        end

        // Short and threshold-length pulses on line 3.
        lines     = 16'h0000;
        chg_ready = 1'b1;
        apply_reset("pulse_reset");
        run(SET, "pulse_idle");
        seen_rise = {W{1'b0}};
        seen_fall = {W{1'b0}};
        lines = 16'h0008;
        run(3, "pulse3_hi");
        lines = 16'h0000;
        run(SET + 2, "pulse3_lo");
        check_val("pulse3_rise", 64'(seen_rise[3]), 64'(L <= 3));
        check_val("pulse3_out", 64'(out), 64'd0);
        seen_rise = {W{1'b0}};
        seen_fall = {W{1'b0}};
        lines = 16'h0008;
        run(4, "pulse4_hi");
        lines = 16'h0000;
        run(SET + 2, "pulse4_lo");
        check_val("pulse4_rise", 64'(seen_rise[3]), 64'd1);
        check_val("pulse4_fall", 64'(seen_fall[3]), 64'd1);
        check_val("pulse4_out", 64'(out), 64'd0);

        // Reset in the middle of an event, then a held-high line re-rises.
        lines = 16'h00F0;
        run(S + L + 1, "mid_event");
        apply_reset("mid_reset");
        run(S + L, "after_reset");
        check_val("held_high_rise", 64'(rise), 64'h00F0);

        // Table-driven handshake/overflow/enable vectors.
        lines     = 16'h0000;
        chg_ready = 1'b0;
        apply_reset("table_reset");
        for (int v = 0; v < 15; v++) begin
            lines     = tbl[v].lines;
            en        = tbl[v].en;
            chg_ready = tbl[v].rdy;
            ovf_clr   = tbl[v].clr;
            run(tbl[v].cyc, $sformatf("tbl%0d_model", v));
            check_val($sformatf("tbl%0d_out", v), 64'(out), 64'(tbl[v].exp_out));
            check_val($sformatf("tbl%0d_valid", v), 64'(chg_valid), 64'(tbl[v].exp_valid));
            check_val($sformatf("tbl%0d_data", v), 64'(chg_data), 64'(tbl[v].exp_data));
            check_val($sformatf("tbl%0d_ovf", v), 64'(ovf), 64'(tbl[v].exp_ovf));
        end

        // Randomised traffic against the model, with one reset in the middle.
        ovf_clr = 1'b0;
        for (int c = 0; c < 800; c++) begin
            int bit_sel;
            if ($urandom_range(0, 2) == 0) begin
                bit_sel = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3))
                                                      : int'($urandom_range(0, W - 1));
                lines = lines ^ (16'h0001 << bit_sel);
            end
            en        = ($urandom_range(0, 15) != 0);
            chg_ready = ($urandom_range(0, 2) == 0);
            ovf_clr   = ($urandom_range(0, 20) == 0);
            if (c == 400) apply_reset("rand_reset");
            step("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
